mux4_rr_arbiter: RTL and testbench

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner sequencer for a shared 4:1 MUX4 datapath: grants one requester at a time
// for a burst of up to BURST_LEN captures. Define MUX4_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest).
//
// state | meaning
// IDLE  | no owner; gnt=0, sel holds, winner picked from req
// BUSY  | owner holds the channel; mux_out captured each cycle the owner keeps requesting
module mux4_rr_arbiter #(
    parameter int BURST_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       mux_out,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       dout,
    output logic       dout_valid,
    output logic [1:0] dout_src
);

    localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] count;
    logic [7:0] count_nxt;
    logic [7:0] count_inc;
    logic [1:0] last;
    logic [1:0] last_nxt;
    logic [1:0] winner;
    logic [1:0] sel_nxt;
    logic [3:0] gnt_nxt;
    logic       dout_nxt;
    logic       dout_valid_nxt;
    logic [1:0] dout_src_nxt;

`ifdef MUX4_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                winner = 2'(i);
            end
        end
    end
`else
    logic [1:0] cand;
    logic       found;

    // Search starts one past the previous owner, so the previous owner is checked last.
    always_comb begin
        winner = last;
        cand   = 2'd0;
        found  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end
`endif

    assign count_inc = count + 8'd1;

    always_comb begin
        state_nxt      = state;
        gnt_nxt        = gnt;
        sel_nxt        = sel;
        count_nxt      = count;
        last_nxt       = last;
        dout_nxt       = dout;
        dout_valid_nxt = 1'b0;
        dout_src_nxt   = dout_src;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = BUSY;
                    gnt_nxt   = 4'b0001 << winner;
                    sel_nxt   = winner;
                    count_nxt = 8'd0;
                end
            end
            BUSY: begin
                if (req[sel]) begin
                    dout_nxt       = mux_out;
                    dout_src_nxt   = sel;
                    dout_valid_nxt = 1'b1;
                    count_nxt      = count_inc;
                    if (count_inc == BURST_MAX) begin
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                        last_nxt  = sel;
                    end
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    last_nxt  = sel;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
            end
        endcase
    end

    // last resets to 3 so requester 0 is the first candidate after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= 4'b0000;
            sel        <= 2'd0;
            count      <= 8'd0;
            last       <= 2'd3;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            dout_src   <= 2'd0;
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            sel        <= sel_nxt;
            count      <= count_nxt;
            last       <= last_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            dout_src   <= dout_src_nxt;
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: three instances (BURST_LEN 8, 2, 1) share stimulus; a queue scoreboard
// checks captured data, a per-cycle reference checks gnt/sel/busy, and directed scenarios check grant order.
module tb_mux4_rr_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic            mux_out;
    logic [3:0]      req;
    logic [2:0][1:0] sel_v;
    logic [2:0][1:0] src_v;
    logic [2:0][3:0] gnt_v;
    logic [2:0]      busy_v;
    logic [2:0]      dout_v;
    logic [2:0]      vld_v;

    int n_total = 0;
    int n_bad   = 0;
    localparam int BL[3] = '{8, 2, 1};

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.BURST_LEN(8)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .mux_out(mux_out),
        .sel(sel_v[0]), .gnt(gnt_v[0]), .busy(busy_v[0]),
        .dout(dout_v[0]), .dout_valid(vld_v[0]), .dout_src(src_v[0])
    );
    mux4_rr_arbiter #(.BURST_LEN(2)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .mux_out(mux_out),
        .sel(sel_v[1]), .gnt(gnt_v[1]), .busy(busy_v[1]),
        .dout(dout_v[1]), .dout_valid(vld_v[1]), .dout_src(src_v[1])
    );
    mux4_rr_arbiter #(.BURST_LEN(1)) u_dut2 (
        .clk(clk), .rst(rst), .req(req), .mux_out(mux_out),
        .sel(sel_v[2]), .gnt(gnt_v[2]), .busy(busy_v[2]),
        .dout(dout_v[2]), .dout_valid(vld_v[2]), .dout_src(src_v[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] lst);
        logic [7:0] dbl;
        logic [3:0] rot;
`ifdef MUX4_ARB_FIXED_PRIO_EN
        dbl = 8'd0;
        rot = 4'd0;
        if (r[0]) return 2'd0;
        if (r[1]) return 2'd1;
        if (r[2]) return 2'd2;
        return 2'd3;
`else
        dbl = {r, r};
        rot = 4'(dbl >> ({1'b0, lst} + 3'd1));
        if (rot[0]) return lst + 2'd1;
        if (rot[1]) return lst + 2'd2;
        if (rot[2]) return lst + 2'd3;
        return lst;
`endif
    endfunction

    function automatic int enc(input logic [3:0] g);
        case (g)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    // Reference state, one set per instance
    logic       m_busy[3];
    logic [1:0] m_sel[3];
    logic [1:0] m_last[3];
    int         m_cnt[3];
    logic       m_vld[3];
    logic [2:0] exp_q[3][$];

    int         cyc = 0;
    int         glog_idx[3][$];
    int         glog_cyc[3][$];
    int         glog_val[3][$];
    int         val_cnt[3];
    logic [3:0] prev_gnt[3];
    logic [3:0] dsh;
    int         dcnt;
    logic [2:0] e_pop;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_busy[k] <= 1'b0;
                m_sel[k]  <= 2'd0;
                m_last[k] <= 2'd3;
                m_cnt[k]  <= 0;
                m_vld[k]  <= 1'b0;
                exp_q[k].delete();
            end else begin
                m_vld[k] <= 1'b0;
                if (!m_busy[k]) begin
                    if (|req) begin
                        m_busy[k] <= 1'b1;
                        m_sel[k]  <= pick(req, m_last[k]);
                        m_cnt[k]  <= 0;
                    end
                end else if (req[m_sel[k]]) begin
                    m_vld[k] <= 1'b1;
                    exp_q[k].push_back({mux_out, m_sel[k]});
                    m_cnt[k] <= m_cnt[k] + 1;
                    if (m_cnt[k] + 1 == BL[k]) begin
                        m_busy[k] <= 1'b0;
                        m_last[k] <= m_sel[k];
                    end
                end else begin
                    m_busy[k] <= 1'b0;
                    m_last[k] <= m_sel[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("gnt%0d", k), 32'(gnt_v[k]), m_busy[k] ? 32'(4'b0001 << m_sel[k]) : 32'd0);
            chk($sformatf("sel%0d", k), 32'(sel_v[k]), 32'(m_sel[k]));
            chk($sformatf("busy%0d", k), 32'(busy_v[k]), 32'(m_busy[k]));
            chk($sformatf("valid%0d", k), 32'(vld_v[k]), 32'(m_vld[k]));
            if (vld_v[k]) begin
                val_cnt[k] <= val_cnt[k] + 1;
                if (exp_q[k].size() == 0) begin
                    chk($sformatf("q%0d_empty", k), 32'd1, 32'd0);
                end else begin
                    e_pop = exp_q[k].pop_front();
                    chk($sformatf("dout%0d", k), 32'(dout_v[k]), 32'(e_pop[2]));
                    chk($sformatf("src%0d", k), 32'(src_v[k]), 32'(e_pop[1:0]));
                end
                if (k == 0 && dcnt < 4) begin
                    dsh  <= {dsh[2:0], dout_v[0]};
                    dcnt <= dcnt + 1;
                end
            end
            if (gnt_v[k] != 4'd0 && prev_gnt[k] == 4'd0) begin
                glog_idx[k].push_back(enc(gnt_v[k]));
                glog_cyc[k].push_back(cyc);
                glog_val[k].push_back(val_cnt[k]);
            end
            prev_gnt[k] <= gnt_v[k];
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 3; k++) begin
            glog_idx[k].delete();
            glog_cyc[k].delete();
            glog_val[k].delete();
            val_cnt[k] = 0;
        end
        dsh  = 4'd0;
        dcnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        clear_logs();
        rst = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt_v[0]), 32'd0);
        chk({tag, "_sel"}, 32'(sel_v[0]), 32'd0);
        chk({tag, "_busy"}, 32'(busy_v[0]), 32'd0);
        chk({tag, "_dout"}, 32'(dout_v[0]), 32'd0);
        chk({tag, "_valid"}, 32'(vld_v[0]), 32'd0);
        chk({tag, "_src"}, 32'(src_v[0]), 32'd0);
    endtask

    int t0;
    int exp_idx;

    initial begin
        for (int k = 0; k < 3; k++) prev_gnt[k] = 4'd0;
        clear_logs();
        rst     = 1'b1;
        req     = 4'd0;
        mux_out = 1'b0;
        step(2);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk);
        #1;

        // Single requester held, BURST_LEN 8: 8 captures, one dead cycle, re-grant to 0
        do_reset();
        req = 4'b0001;
        t0  = cyc;
        step(22);
        chk("a_ngrant", 32'(glog_idx[0].size() >= 2), 32'd1);
        chk("a_first_idx", 32'(glog_idx[0][0]), 32'd0);
        chk("a_latency", 32'(glog_cyc[0][0] - t0), 32'd1);
        chk("a_regrant_idx", 32'(glog_idx[0][1]), 32'd0);
        chk("a_period", 32'(glog_cyc[0][1] - glog_cyc[0][0]), 32'd9);
        chk("a_pulses", 32'(glog_val[0][1] - glog_val[0][0]), 32'd8);

        // All requesting, BURST_LEN 2 and 1
        do_reset();
        req = 4'b1111;
        step(16);
        chk("b_ngrant", 32'(glog_idx[1].size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
`ifdef MUX4_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = i % 4;
`endif
            chk($sformatf("b_order%0d", i), 32'(glog_idx[1][i]), 32'(exp_idx));
            if (i < 4) begin
                chk($sformatf("b_gap%0d", i), 32'(glog_cyc[1][i+1] - glog_cyc[1][i]), 32'd3);
                chk($sformatf("b_pulses%0d", i), 32'(glog_val[1][i+1] - glog_val[1][i]), 32'd2);
                chk($sformatf("b1_order%0d", i), 32'(glog_idx[2][i]), 32'(exp_idx));
                chk($sformatf("b1_gap%0d", i), 32'(glog_cyc[2][i+1] - glog_cyc[2][i]), 32'd2);
                chk($sformatf("b1_pulses%0d", i), 32'(glog_val[2][i+1] - glog_val[2][i]), 32'd1);
            end
        end

        // Owner 2 drops after 3 captures while requester 1 waits
        do_reset();
        req = 4'b0100;
        step(1);
        req = 4'b0110;
        step(3);
        req = 4'b0010;
        step(3);
        chk("c_first_idx", 32'(glog_idx[0][0]), 32'd2);
        chk("c_next_idx", 32'(glog_idx[0][1]), 32'd1);
        chk("c_gap", 32'(glog_cyc[0][1] - glog_cyc[0][0]), 32'd5);
        chk("c_pulses", 32'(glog_val[0][1] - glog_val[0][0]), 32'd3);

        // Data path for requester 3
        do_reset();
        req = 4'b1000;
        step(1);
        mux_out = 1'b1; step(1);
        mux_out = 1'b0; step(1);
        mux_out = 1'b1; step(1);
        mux_out = 1'b1; step(1);
        mux_out = 1'b0; step(2);
        chk("d_pattern", 32'(dsh), 32'b1011);
        chk("d_src", 32'(src_v[0]), 32'd3);

        // Reset mid-burst, then req 1010 held
        do_reset();
        req = 4'b1010;
        step(3);
        rst = 1'b1;
        step(1);
        @(negedge clk);
        chk_outputs_zero("midrst");
        @(posedge clk);
        #1;
        clear_logs();
        rst = 1'b0;
        t0  = cyc;
        step(3);
        chk("e_idx", 32'(glog_idx[0][0]), 32'd1);
        chk("e_latency", 32'(glog_cyc[0][0] - t0), 32'd1);

        // req 0101 held: fixed priority never serves 2, round-robin alternates
        do_reset();
        req = 4'b0101;
        step(40);
        chk("f_ngrant", 32'(glog_idx[0].size() >= 4), 32'd1);
        for (int i = 0; i < glog_idx[0].size(); i++) begin
`ifdef MUX4_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = (i % 2 == 1) ? 2 : 0;
`endif
            chk($sformatf("f_order%0d", i), 32'(glog_idx[0][i]), 32'(exp_idx));
        end

        // Random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            mux_out = 1'($urandom_range(0, 1));
            rst     = ($urandom_range(0, 59) == 0);
            step(1);
        end
        rst = 1'b0;
        req = 4'd0;
        step(12);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
